// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues single-outstanding imem requests and
// presents one instruction per delivery (or a bubble) to fetch/decode.
module fetch_unit #(
  parameter int unsigned                 PC_WIDTH    = 16,
  parameter int unsigned                 INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0]         RESET_PC    = '0,
  parameter int unsigned                 PC_INCR     = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic                   nop
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t                 state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [PC_WIDTH-1:0]    pc_last_q;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic                   kill_q, kill_d;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      pc_last_q <= RESET_PC;
      instr_q   <= '0;
      kill_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pc_last_q <= pc_out;
      instr_q   <= instr_d;
      kill_q    <= kill_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    kill_d   = kill_q;
    imem_req = 1'b0;
    nop      = 1'b1;

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        imem_req = 1'b1;
        if (imem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            instr_d = imem_rdata;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        nop = stall;
        if (!stall) begin
          pc_d    = pc_q + PC_WIDTH'(PC_INCR);
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Redirect overrides the normal transitions above; a request already
    // granted to the old address is marked for discard via kill_q.
    if (branch_taken) begin
      pc_d = branch_target;
      nop  = 1'b1;
      case (state_q)
        S_IDLE, S_HOLD: begin
          instr_d = '0;
          state_d = S_REQ;
        end
        S_REQ: begin
          if (imem_gnt) begin
            kill_d  = 1'b1;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            instr_d = instr_q;
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            kill_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_addr = pc_q;
  // pc_out tracks pc_q in HOLD and otherwise keeps the last presented value.
  assign pc_out    = (state_q == S_HOLD) ? pc_q : pc_last_q;
  assign instr_out = nop ? '0 : instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural instruction memory plus a delivery
// scoreboard; scenario tasks push expected deliveries before they occur.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, stall, branch_taken;
  logic [15:0] branch_target;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [15:0] imem_addr, imem_rdata, pc_out, instr_out;
  logic        nop;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] sb[$];
  int          mem_lat   = 1;
  int          gnt_block = 0;
  bit          pending   = 1'b0;
  int          lat_cnt   = 0;
  logic [15:0] pend_addr = '0;
  bit          mon_en    = 1'b0;

  always #5 clk = ~clk;

  fetch_unit #(
    .PC_WIDTH(16), .INSTR_WIDTH(16), .RESET_PC(16'h0000), .PC_INCR(1)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc_out(pc_out), .instr_out(instr_out), .nop(nop)
  );

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == 16'h0005) return 16'h1234;
    return a ^ 16'hA001;
  endfunction

  // Memory: grants after gnt_block request cycles, responds mem_lat cycles after grant.
  always @(negedge clk) begin
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    if (pending) begin
      lat_cnt = lat_cnt - 1;
      if (lat_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr);
        pending     = 1'b0;
      end
    end else if (imem_req === 1'b1) begin
      if (gnt_block > 0) gnt_block = gnt_block - 1;
      else begin
        imem_gnt  = 1'b1;
        pending   = 1'b1;
        pend_addr = imem_addr;
        lat_cnt   = mem_lat;
      end
    end
  end

  // Scoreboard consumer: every nop=0 cycle must match the oldest expectation.
  always @(negedge clk) begin
    logic [31:0] exp;
    if (mon_en && reset === 1'b1) begin
      n_checks++;
      if (nop === 1'b0) begin
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_delivery: pc_out=%h instr_out=%h, none expected", pc_out, instr_out);
        end else begin
          exp = sb.pop_front();
          if ({pc_out, instr_out} !== exp) begin
            n_fail++;
            $display("FAIL delivery: got pc=%h instr=%h, expected pc=%h instr=%h",
                     pc_out, instr_out, exp[31:16], exp[15:0]);
          end
        end
      end else if (instr_out !== 16'h0000) begin
        n_fail++;
        $display("FAIL instr_when_nop: instr_out=%h nop=%b, expected 0000 with nop=1", instr_out, nop);
      end
    end
  end

  task automatic wait_req(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (imem_req === 1'b1) found = 1'b1;
    end
  endtask

  task automatic wait_deliv(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (nop === 1'b0) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    repeat (3) @(negedge clk);
    n_checks += 5;
    if (imem_req !== 1'b0)      begin n_fail++; $display("FAIL reset_req: got %b, expected 0", imem_req); end
    if (imem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_addr: got %h, expected 0000", imem_addr); end
    if (pc_out !== 16'h0000)    begin n_fail++; $display("FAIL reset_pc_out: got %h, expected 0000", pc_out); end
    if (instr_out !== 16'h0000) begin n_fail++; $display("FAIL reset_instr: got %h, expected 0000", instr_out); end
    if (nop !== 1'b1)           begin n_fail++; $display("FAIL reset_nop: got %b, expected 1", nop); end
    mon_en = 1'b1;
  endtask

  task automatic test_first_fetch();
    bit found;
    sb.push_back({16'h0000, 16'hA001});
    reset = 1'b1;
    wait_req(10, found);
    n_checks++;
    if (!found || imem_addr !== 16'h0000) begin n_fail++; $display("FAIL first_req: found=%b addr=%h, expected 0000", found, imem_addr); end
    wait_deliv(10, found);
    n_checks++;
    if (!found || pc_out !== 16'h0000 || instr_out !== 16'hA001) begin
      n_fail++; $display("FAIL first_deliv: found=%b pc=%h instr=%h, expected 0000/A001", found, pc_out, instr_out);
    end
    @(negedge clk);
    n_checks += 2;
    if (nop !== 1'b1) begin n_fail++; $display("FAIL single_cycle_nop: got %b, expected 1", nop); end
    if (imem_req !== 1'b1 || imem_addr !== 16'h0001) begin
      n_fail++; $display("FAIL second_req: req=%b addr=%h, expected 1/0001", imem_req, imem_addr);
    end
  endtask

  task automatic test_stall();
    bit found = 1'b0;
    for (int a = 1; a <= 4; a++) begin
      logic [15:0] av;
      av = 16'(a);
      sb.push_back({av, av ^ 16'hA001});
    end
    sb.push_back({16'h0005, 16'h1234});
    for (int k = 0; k < 8 && !(found && imem_addr === 16'h0005); k++) wait_req(10, found);
    n_checks++;
    if (!found || imem_addr !== 16'h0005) begin n_fail++; $display("FAIL stall_req5: found=%b addr=%h, expected 0005", found, imem_addr); end
    stall = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      n_checks += 2;
      if (nop !== 1'b1)      begin n_fail++; $display("FAIL stall_nop[%0d]: got %b, expected 1", i, nop); end
      if (imem_req !== 1'b0) begin n_fail++; $display("FAIL stall_req[%0d]: got %b, expected 0", i, imem_req); end
    end
    @(posedge clk);
    #1 stall = 1'b0;
    @(negedge clk);
    n_checks++;
    if (nop !== 1'b0 || pc_out !== 16'h0005 || instr_out !== 16'h1234) begin
      n_fail++; $display("FAIL stall_release: nop=%b pc=%h instr=%h, expected 0/0005/1234", nop, pc_out, instr_out);
    end
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0006) begin
      n_fail++; $display("FAIL stall_next_req: req=%b addr=%h, expected 1/0006", imem_req, imem_addr);
    end
  endtask

  task automatic test_branch_wait();
    bit found;
    sb.push_back({16'h0006, 16'hA007});
    @(negedge clk);
    mem_lat = 3;
    wait_req(10, found);
    n_checks++;
    if (!found || imem_addr !== 16'h0007) begin n_fail++; $display("FAIL bw_req7: found=%b addr=%h, expected 0007", found, imem_addr); end
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (i == 1) begin branch_taken = 1'b1; branch_target = 16'h0040; end
      if (i == 2) branch_taken = 1'b0;
      if (i == 3) mem_lat = 1;
      n_checks++;
      if (nop !== 1'b1) begin n_fail++; $display("FAIL bw_nop[%0d]: got %b, expected 1", i, nop); end
    end
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin
      n_fail++; $display("FAIL bw_redirect_req: req=%b addr=%h, expected 1/0040", imem_req, imem_addr);
    end
    sb.push_back({16'h0040, 16'hA041});
    wait_deliv(10, found);
    n_checks++;
    if (!found || pc_out !== 16'h0040) begin n_fail++; $display("FAIL bw_deliv: found=%b pc=%h, expected 0040", found, pc_out); end
  endtask

  task automatic test_branch_req();
    bit found;
    gnt_block = 5;
    wait_req(10, found);
    n_checks++;
    if (!found || imem_addr !== 16'h0041) begin n_fail++; $display("FAIL br_req41: found=%b addr=%h, expected 0041", found, imem_addr); end
    @(negedge clk);
    branch_taken = 1'b1; branch_target = 16'h0100;
    for (int i = 3; i <= 5; i++) begin
      @(negedge clk);
      branch_taken = 1'b0;
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 16'h0100) begin
        n_fail++; $display("FAIL br_hold_req[%0d]: req=%b addr=%h, expected 1/0100", i, imem_req, imem_addr);
      end
    end
    sb.push_back({16'h0100, 16'hA101});
    wait_deliv(12, found);
    n_checks++;
    if (!found || pc_out !== 16'h0100) begin n_fail++; $display("FAIL br_deliv: found=%b pc=%h, expected 0100", found, pc_out); end
  endtask

  task automatic test_wrap();
    bit found;
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0101) begin
      n_fail++; $display("FAIL wrap_req101: req=%b addr=%h, expected 1/0101", imem_req, imem_addr);
    end
    branch_taken = 1'b1; branch_target = 16'hFFFF;
    @(negedge clk);
    branch_taken = 1'b0;
    sb.push_back({16'hFFFF, 16'h5FFE});
    wait_req(10, found);
    n_checks++;
    if (!found || imem_addr !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_reqFFFF: found=%b addr=%h, expected FFFF", found, imem_addr); end
    wait_deliv(10, found);
    n_checks++;
    if (!found || pc_out !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_deliv: found=%b pc=%h, expected FFFF", found, pc_out); end
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
      n_fail++; $display("FAIL wrap_next: req=%b addr=%h, expected 1/0000", imem_req, imem_addr);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    sb.push_back({16'h0000, 16'hA001});
    wait_deliv(10, found);
    mem_lat = 4;
    wait_req(10, found);
    n_checks++;
    if (!found || imem_addr !== 16'h0001) begin n_fail++; $display("FAIL rm_req1: found=%b addr=%h, expected 0001", found, imem_addr); end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (i == 0) mem_lat = 1;
      n_checks += 5;
      if (imem_req !== 1'b0)      begin n_fail++; $display("FAIL rm_req[%0d]: got %b, expected 0", i, imem_req); end
      if (imem_addr !== 16'h0000) begin n_fail++; $display("FAIL rm_addr[%0d]: got %h, expected 0000", i, imem_addr); end
      if (pc_out !== 16'h0000)    begin n_fail++; $display("FAIL rm_pc_out[%0d]: got %h, expected 0000", i, pc_out); end
      if (instr_out !== 16'h0000) begin n_fail++; $display("FAIL rm_instr[%0d]: got %h, expected 0000", i, instr_out); end
      if (nop !== 1'b1)           begin n_fail++; $display("FAIL rm_nop[%0d]: got %b, expected 1", i, nop); end
    end
    reset = 1'b1;
    sb.push_back({16'h0000, 16'hA001});
    wait_req(10, found);
    n_checks++;
    if (!found || imem_addr !== 16'h0000) begin n_fail++; $display("FAIL rm_first_req: found=%b addr=%h, expected 0000", found, imem_addr); end
    wait_deliv(12, found);
    n_checks++;
    if (!found || pc_out !== 16'h0000 || instr_out !== 16'hA001) begin
      n_fail++; $display("FAIL rm_deliv: found=%b pc=%h instr=%h, expected 0000/A001", found, pc_out, instr_out);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    test_reset();
    test_first_fetch();
    test_stall();
    test_branch_wait();
    test_branch_req();
    test_wrap();
    test_reset_mid();
    @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: %0d pending, expected 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
